// File: rtl/m1553_multi_timer.sv
// m1553_multi_timer
// Runtime-programmable elapsed-cycle timer used for MIL-STD-1553 protocol timing
// (response timeout, inter-message gap, mid-bit sampling windows).
//
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_clear             synchronous clear to IDLE (count 0, sticky flags cleared)
//   i_start             (re)start; samples i_limit and i_periodic, count restarts at 0
//   i_en                count enable while running (pause when 0)
//   i_periodic          1 = auto-reload on expiry, sampled at start
//   i_limit             period in cycles, sampled at start
//   i_ack               clears sticky o_expired / o_overrun
//   i_win_lo, i_win_hi  packed per-window inclusive bounds; hi == 0 disables a window
//   o_count             elapsed enabled cycles since start/reload
//   o_busy              timer is running
//   o_expired_pulse     one-cycle pulse per expiry
//   o_expired           sticky expiry flag
//   o_overrun           sticky: expiry while o_expired was still set
//   o_in_window         count within [lo,hi] while running, per window
//   o_win_enter         one-cycle pulse on window entry, per window
module m1553_multi_timer #(
  parameter int Width      = 16,
  parameter int NumWindows = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_clear,
  input  logic                          i_start,
  input  logic                          i_en,
  input  logic                          i_periodic,
  input  logic [Width-1:0]              i_limit,
  input  logic                          i_ack,
  input  logic [NumWindows*Width-1:0]   i_win_lo,
  input  logic [NumWindows*Width-1:0]   i_win_hi,
  output logic [Width-1:0]              o_count,
  output logic                          o_busy,
  output logic                          o_expired_pulse,
  output logic                          o_expired,
  output logic                          o_overrun,
  output logic [NumWindows-1:0]         o_in_window,
  output logic [NumWindows-1:0]         o_win_enter
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [Width-1:0] ONE  = Width'(1);
  localparam logic [Width-1:0] ZERO = '0;

  // A window with hi == 0 is disabled; lo > hi naturally never matches.
  function automatic logic win_match(input logic [Width-1:0] lo,
                                     input logic [Width-1:0] hi,
                                     input logic [Width-1:0] cnt);
    return (hi != ZERO) && (lo <= cnt) && (cnt <= hi);
  endfunction

  state_t                 state_q, state_d;
  logic [Width-1:0]       count_q, count_d;
  logic [Width-1:0]       limit_q, limit_d;
  logic                   mode_q, mode_d;
  logic                   expired_q, expired_d;
  logic                   overrun_q, overrun_d;
  logic                   pulse_q, pulse_d;
  logic [NumWindows-1:0]  in_window;
  logic [NumWindows-1:0]  in_prev_q;
  logic [NumWindows-1:0]  win_enter_q;

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      limit_q     <= '0;
      mode_q      <= 1'b0;
      expired_q   <= 1'b0;
      overrun_q   <= 1'b0;
      pulse_q     <= 1'b0;
      in_prev_q   <= '0;
      win_enter_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      limit_q     <= limit_d;
      mode_q      <= mode_d;
      expired_q   <= expired_d;
      overrun_q   <= overrun_d;
      pulse_q     <= pulse_d;
      in_prev_q   <= in_window;
      win_enter_q <= in_window & ~in_prev_q;
    end
  end

  // Next-state and command decode: clear > start > counting
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    limit_d   = limit_q;
    mode_d    = mode_q;
    expired_d = expired_q;
    overrun_d = overrun_q;
    pulse_d   = 1'b0;

    if (i_clear) begin
      state_d   = IDLE;
      count_d   = '0;
      expired_d = 1'b0;
      overrun_d = 1'b0;
    end else if (i_start) begin
      limit_d   = i_limit;
      mode_d    = i_periodic;
      count_d   = '0;
      expired_d = 1'b0;
      overrun_d = 1'b0;
      if (i_limit == ZERO) begin
        // Zero-length period expires on the start edge itself; reloading a
        // zero period would fire forever, so it is always one-shot.
        state_d   = DONE;
        mode_d    = 1'b0;
        pulse_d   = 1'b1;
        expired_d = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else begin
      if (i_ack) begin
        expired_d = 1'b0;
        overrun_d = 1'b0;
      end
      if (state_q == RUN && i_en) begin
        if (count_q == limit_q - ONE) begin
          pulse_d   = 1'b1;
          expired_d = 1'b1;
          // An ack on the same edge wins over raising overrun.
          if (expired_q && !i_ack) overrun_d = 1'b1;
          if (mode_q) begin
            count_d = '0;
          end else begin
            count_d = limit_q;
            state_d = DONE;
          end
        end else begin
          count_d = count_q + ONE;
        end
      end
    end
  end

  // Compare windows, combinational from the registered count
  for (genvar n = 0; n < NumWindows; n++) begin : g_win
    assign in_window[n] = (state_q == RUN) &&
                          win_match(i_win_lo[n*Width +: Width],
                                    i_win_hi[n*Width +: Width], count_q);
  end

  assign o_count         = count_q;
  assign o_busy          = (state_q == RUN);
  assign o_expired_pulse = pulse_q;
  assign o_expired       = expired_q;
  assign o_overrun       = overrun_q;
  assign o_in_window     = in_window;
  assign o_win_enter     = win_enter_q;

endmodule

// File: doc/m1553_multi_timer.md
# m1553_multi_timer

Runtime-programmable elapsed-cycle timer for MIL-STD-1553 protocol timing: response timeout, inter-message gap and mid-bit sampling windows. It generalises the fixed-parameter timer in several ways. The terminal count is loaded at start, the count width is parametrised, and the number of compare windows is set by a parameter. It adds a periodic auto-reload mode and a sticky expiry flag with acknowledge and overrun detection. Instances sit inside the encoder, decoder and RT/BC sequencers, wherever a timeout or window is needed.

## Interface
- Width, 16, width of count, limit and window bounds
- NumWindows, 2, number of independent compare windows (≥1)

- i_clk  in  1  system clock, all state on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_clear  in  1  synchronous clear: to IDLE, count 0, flags cleared
- i_start  in  1  (re)start: samples i_limit and i_periodic, count restarts at 0
- i_en  in  1  count-enable qualifier while RUN (pause when 0)
- i_periodic  in  1  mode sampled at start: 1 = auto-reload on expiry
- i_limit  in  Width  period in cycles, sampled at start
- i_ack  in  1  clears sticky o_expired and o_overrun
- i_win_lo  in  NumWindows×Width  window lower bounds, inclusive; static during RUN
- i_win_hi  in  NumWindows×Width  window upper bounds, inclusive; 0 disables window
- o_count  out  Width  elapsed enabled cycles since start/reload
- o_busy  out  1  state == RUN
- o_expired_pulse  out  1  one-cycle pulse per expiry
- o_expired  out  1  sticky expiry flag
- o_overrun  out  1  sticky: expiry occurred while o_expired already set
- o_in_window  out  NumWindows  count within [lo,hi] while RUN
- o_win_enter  out  NumWindows  one-cycle pulse on window entry

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE. All outputs reset to 0: o_count=0, all flags/pulses 0.
- Command priority per edge: i_clear > i_start > counting. i_clear: state IDLE, count 0, o_expired=0, o_overrun=0, registers limit_q/mode_q unchanged.
- i_start (any state): limit_q←i_limit, mode_q←i_periodic, count←0, o_expired←0, o_overrun←0, state RUN. If i_limit==0: state DONE directly, count 0, o_expired_pulse and o_expired set on that edge; mode forced one-shot.
- RUN, i_en=1: if count==limit_q−1 → expiry event; else count←count+1. RUN, i_en=0: count holds, no events.
- Expiry event, one-shot: count←limit_q, state DONE. Periodic: count←0, stay RUN.
- Every expiry event: o_expired_pulse=1 for the next cycle; o_expired←1; if o_expired already 1 and i_ack=0, o_overrun←1.
- i_ack: clears o_expired and o_overrun unless an expiry event occurs the same edge; set wins, and overrun is then not raised.
- DONE: count holds limit_q, o_busy=0; only i_start or i_clear leave it.
- Windows, per n: enabled iff win_hi[n]≠0; o_in_window[n] = RUN && enabled && win_lo[n] ≤ count ≤ win_hi[n], combinational from registered count. lo>hi never matches.
- o_win_enter[n]: registered rising edge of o_in_window[n]; restart at count 0 into a window with lo=0 produces a fresh pulse if previous cycle was outside.
- Arithmetic unsigned, Width bits; count never exceeds limit_q so no wrap. limit_q = 2^Width−1 is legal.

## Timing
- Start sampled at edge 0 → o_busy=1, o_count=0 after edge 0; o_count=k after k enabled edges.
- One-shot, limit L≥1, i_en held 1: after edge L, o_count=L, state DONE, o_expired_pulse high for exactly that cycle, o_expired=1.
- Periodic: o_expired_pulse every L cycles (after edges L, 2L, …); o_count sequence 0..L−1 repeating.
- o_in_window: same cycle as matching o_count. o_win_enter: one cycle later.
- Async reset mid-RUN: all outputs 0 immediately; no pulse on reset release.

## Test plan
- One-shot, limit=10, i_en=1: o_count 0..9, then 10 with o_expired_pulse for 1 cycle at edge 10; o_busy drops; count holds 10.
- Periodic, limit=4, no ack: pulses at edges 4,8,12; o_expired=1 after edge 4, o_overrun=1 after edge 8; i_ack at edge 9 clears both; ack coincident with edge 12 leaves o_expired=1, o_overrun=0.
- i_en toggled 1/0 alternately, limit=6: expiry at edge 12; count holds on disabled cycles.
- Window lo=3, hi=5, limit=10: o_in_window high for counts 3,4,5; o_win_enter single pulse when count=4 is shown; window hi=0 never asserts.
- limit=0 start: DONE immediately, pulse and sticky set, o_busy=0; i_start with i_clear same edge → IDLE, count 0.
- Assert i_rst_n low at count=7 in periodic run: all outputs 0 asynchronously; after release, IDLE until next i_start.
